bctrl_tx_framer: RTL and testbench
==================================

BCTRL_TX_FRAMER -- requirements
Module: bctrl_tx_framer

Interface
REQ-001 Parameter HEADER, default 16'hEB90: frame sync word, sent MSB first.
REQ-002 Parameter GAP_CYCLES, default 8: minimum o_tx_en-low clocks between frames.
REQ-003 Parameter POLYNOMIAL, default 16'h8005: CRC16 generator.
REQ-004 Parameter INIT_VALUE, default 16'hFFFF: CRC16 preset.
REQ-005 i_clk20m  input  1  sole clock; all logic on its rising edge.
REQ-006 i_rst  input  1  reset; synchronous and active-high.
REQ-007 i_start  input  1  frame request, sampled in IDLE only.
REQ-008 i_len  input  8  payload byte count, sampled with i_start.
REQ-009 s_byte  input  8  payload byte.
REQ-010 s_valid  input  1  s_byte valid.
REQ-011 s_ready  output  1  one-cycle pulse that consumes s_byte.
REQ-012 o_tx_data  output  1  serial bit, MSB first.
REQ-013 o_tx_en  output  1  high for every frame bit.
REQ-014 o_busy  output  1  high from accepted start to end of GAP.
REQ-015 o_done  output  1  one-cycle pulse after the last CRC bit.
REQ-016 o_err_underrun  output  1  one-cycle pulse on payload underrun abort.

Function
REQ-017 Frame layout SHALL be HEADER(16b), i_len(8b), payload(i_len bytes), CRC16(16b); one bit per clock, contiguous, o_tx_en high throughout.
REQ-018 States SHALL be IDLE -> HDR -> LEN -> PAYLOAD -> CRC -> GAP -> IDLE.
REQ-019 In IDLE, i_start=1 with i_len!=0 SHALL latch i_len and move to HDR; the first header bit appears on the next cycle.
REQ-020 i_start with i_len=0 SHALL be ignored: no frame, no o_done.
REQ-021 i_start outside IDLE SHALL be ignored.
REQ-022 s_ready SHALL pulse for one cycle, one clock before each payload byte's first bit; the byte is taken only if s_valid=1 in that cycle.
REQ-023 s_valid=0 during an s_ready pulse SHALL abort the frame: o_tx_en falls next cycle, o_err_underrun pulses, and the state goes to GAP (no o_done).
REQ-024 CRC SHALL cover payload bits only: bit-serial, non-reflected, no output XOR, preset to INIT_VALUE at each frame start.
REQ-025 CRC bits SHALL be sent MSB first immediately after the last payload bit.
REQ-026 o_tx_en high time SHALL be exactly (5+i_len)*8 clocks.
REQ-027 o_done SHALL pulse in the first GAP cycle.
REQ-028 GAP SHALL hold o_tx_en=0 and o_busy=1 for exactly GAP_CYCLES clocks, then return to IDLE, where a start is accepted.
REQ-029 o_tx_data SHALL be 0 whenever o_tx_en=0.
REQ-030 i_len=255 SHALL need no special handling; the byte counter uses no wrap-around beyond 8 bits.

Reset
REQ-031 i_rst=1 SHALL force IDLE at the next edge, from any state and mid-frame.
REQ-032 During and after reset, all outputs SHALL be 0 (o_tx_data, o_tx_en, o_busy, o_done, o_err_underrun, s_ready).
REQ-033 Reset SHALL clear the CRC register, bit counter and byte counter.
REQ-034 Reset SHALL discard any partial frame without pulsing o_done or o_err_underrun.

Structure
REQ-035 Package bctrl_pkg SHALL hold the state encoding and the HEADER, GAP_CYCLES, POLYNOMIAL and INIT_VALUE defaults.
REQ-036 The receive-side CRC16 SHALL use the same package values.
REQ-037 The bit-serial CRC SHALL be a sub-module crc16_serial with ports clk, rst, init, bit_in, bit_en and crc.
REQ-038 The top level SHALL contain the FSM, the shift register and the counters.

Verification
REQ-039 Payload "123456789" (0x31..0x39), i_len=9: stream = EB90, 09, payload, AEE7; o_tx_en high 112 clocks; o_done pulses once.
REQ-040 i_len=1, byte 0x00, s_valid always high: 48 en-clocks; CRC field matches the bench model.
REQ-041 s_valid dropped at the 3rd s_ready pulse of a 5-byte frame: o_tx_en falls next cycle, o_err_underrun pulses, no o_done, GAP of 8 clocks follows.
REQ-042 i_rst asserted at bit 20 of a frame: all outputs 0 next cycle; a new frame started 2 clocks after reset release is correct.
REQ-043 i_start during GAP, and i_start with i_len=0: both ignored; a start on the first IDLE cycle after GAP is accepted.
REQ-044 i_len=255, random payload: 2080 en-clocks and CRC matches the model.

Source files
------------

// File: rtl/bctrl_pkg.sv
// rtl/bctrl_pkg.sv - shared state encoding, framer defaults and CRC16 step function
package bctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC,
    ST_GAP
  } state_e;

  localparam logic [15:0] HEADER_DEF     = 16'hEB90;
  localparam int          GAP_CYCLES_DEF = 8;
  localparam logic [15:0] POLY_DEF       = 16'h8005;
  localparam logic [15:0] INIT_DEF       = 16'hFFFF;

  // One non-reflected CRC16 step; also usable by the receive-side checker.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        bit_in,
                                             input logic [15:0] poly);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/bctrl_tx_framer_if.sv
// rtl/bctrl_tx_framer_if.sv - payload byte handshake between source and framer
interface bctrl_tx_framer_if;
  logic [7:0] s_byte;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_byte, output s_valid, input  s_ready);
  modport slave  (input  s_byte, input  s_valid, output s_ready);
endinterface

// File: rtl/bctrl_tx_framer_crc16.sv
// rtl/bctrl_tx_framer_crc16.sv - bit-serial CRC16, preset by init, cleared by reset
module crc16_serial
  import bctrl_pkg::*;
#(
  parameter logic [15:0] POLYNOMIAL = POLY_DEF,
  parameter logic [15:0] INIT_VALUE = INIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        bit_in,
  input  logic        bit_en,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT_VALUE;
    end else if (bit_en) begin
      crc_d = crc16_step(crc_q, bit_in, POLYNOMIAL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/bctrl_tx_framer.sv
// rtl/bctrl_tx_framer.sv - serial frame transmitter: header, length, payload, CRC16, gap
module bctrl_tx_framer
  import bctrl_pkg::*;
#(
  parameter logic [15:0] HEADER     = HEADER_DEF,
  parameter int          GAP_CYCLES = GAP_CYCLES_DEF,
  parameter logic [15:0] POLYNOMIAL = POLY_DEF,
  parameter logic [15:0] INIT_VALUE = INIT_DEF
) (
  input  logic                     i_clk20m,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [7:0]               i_len,
  bctrl_tx_framer_if.slave         s_if,
  output logic                     o_tx_data,
  output logic                     o_tx_en,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err_underrun
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  len_q, len_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        crc_init, crc_en, fetch;
  logic [15:0] crc;

  crc16_serial #(
    .POLYNOMIAL (POLYNOMIAL),
    .INIT_VALUE (INIT_VALUE)
  ) u_crc (
    .clk    (i_clk20m),
    .rst    (i_rst),
    .init   (crc_init),
    .bit_in (shreg_q[15]),
    .bit_en (crc_en),
    .crc    (crc)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    crc_init   = 1'b0;
    crc_en     = (state_q == ST_PAYLOAD);
    fetch      = 1'b0;
    s_if.s_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start && (i_len != 8'd0)) begin
          state_d    = ST_HDR;
          shreg_d    = HEADER;
          bit_cnt_d  = 4'd15;
          byte_cnt_d = i_len;
          len_d      = i_len;
          crc_init   = 1'b1;
        end
      end
      ST_HDR: begin
        shreg_d   = {shreg_q[14:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 4'd1;
        if (bit_cnt_q == 4'd0) begin
          state_d   = ST_LEN;
          shreg_d   = {len_q, 8'h00};
          bit_cnt_d = 4'd7;
        end
      end
      ST_LEN: begin
        shreg_d   = {shreg_q[14:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 4'd1;
        fetch     = (bit_cnt_q == 4'd0);
      end
      ST_PAYLOAD: begin
        shreg_d   = {shreg_q[14:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 4'd1;
        if (bit_cnt_q == 4'd0) begin
          if (byte_cnt_q != 8'd0) begin
            fetch = 1'b1;
          end else begin
            // CRC register already holds every payload bit; it is frozen from here.
            state_d   = ST_CRC;
            bit_cnt_d = 4'd15;
          end
        end
      end
      ST_CRC: begin
        bit_cnt_d = bit_cnt_q - 4'd1;
        if (bit_cnt_q == 4'd0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LAST;
          done_d    = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Next byte is requested on the last bit of the previous field.
    if (fetch) begin
      s_if.s_ready = 1'b1;
      if (s_if.s_valid) begin
        state_d    = ST_PAYLOAD;
        shreg_d    = {s_if.s_byte, 8'h00};
        bit_cnt_d  = 4'd7;
        byte_cnt_d = byte_cnt_q - 8'd1;
      end else begin
        state_d   = ST_GAP;
        gap_cnt_d = GAP_LAST;
        err_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk20m) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= 16'h0000;
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 8'd0;
      len_q      <= 8'd0;
      gap_cnt_q  <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      gap_cnt_q  <= gap_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_tx_en        = (state_q == ST_HDR) || (state_q == ST_LEN) ||
                          (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
  assign o_tx_data      = o_tx_en &&
                          ((state_q == ST_CRC) ? crc[bit_cnt_q] : shreg_q[15]);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = done_q;
  assign o_err_underrun = err_q;

endmodule

// File: tb/tb_bctrl_tx_framer.sv
// tb/tb_bctrl_tx_framer.sv - directed self-checking bench for bctrl_tx_framer
module tb_bctrl_tx_framer;

  logic       clk;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_len;
  logic       o_tx_data, o_tx_en, o_busy, o_done, o_err_underrun;

  bctrl_tx_framer_if sif ();

  bctrl_tx_framer dut (
    .i_clk20m       (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_len          (i_len),
    .s_if           (sif),
    .o_tx_data      (o_tx_data),
    .o_tx_en        (o_tx_en),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err_underrun (o_err_underrun)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] payload [256];
  bit         bits [$];
  int         en_cnt, done_cnt, err_cnt, gap_len, latency, tx_bad;
  bit         timed_out;
  logic [5:0] rst_outs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ payload[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] field(input int pos, input int n);
    logic [15:0] v;
    v = 16'h0000;
    for (int k = 0; k < n; k++) begin
      v = {v[14:0], (pos + k < bits.size()) ? bits[pos + k] : 1'b0};
    end
    return v;
  endfunction

  function automatic logic [5:0] all_outs();
    return {o_tx_data, o_tx_en, o_busy, o_done, o_err_underrun, sif.s_ready};
  endfunction

  // Called at a falling edge; returns at the first IDLE falling edge after the frame.
  task automatic run_frame(input int len, input int drop_at, input int rst_at, input int gap_start_len);
    bit seen_busy, accepted, rst_pend;
    int ready_n, pidx;
    bits.delete();
    en_cnt = 0; done_cnt = 0; err_cnt = 0; gap_len = 0; latency = -1; tx_bad = 0;
    timed_out = 0; rst_outs = '1;
    seen_busy = 0; accepted = 0; rst_pend = 0; ready_n = 0; pidx = 0;
    sif.s_byte = payload[0];
    sif.s_valid = 1'b1;
    i_start = 1'b1;
    i_len = len[7:0];
    @(negedge clk);
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      i_start = 1'b0;
      if (accepted && pidx < 255) begin
        pidx++;
        sif.s_byte = payload[pidx];
      end
      sif.s_valid = 1'b1;
      accepted = 0;
      if (o_tx_en) begin
        bits.push_back(o_tx_data);
        en_cnt++;
        if (latency < 0) latency = cyc;
      end else if (o_tx_data) begin
        tx_bad++;
      end
      if (o_done) done_cnt++;
      if (o_err_underrun) err_cnt++;
      if (o_busy && !o_tx_en) gap_len++;
      if (o_busy) seen_busy = 1;
      if (rst_pend) begin
        rst_outs = all_outs();
        return;
      end
      if (seen_busy && !o_busy) return;
      if (gap_start_len != 0 && o_busy && !o_tx_en && gap_len == 1) begin
        i_start = 1'b1;
        i_len = gap_start_len[7:0];
      end
      if (rst_at >= 0 && en_cnt == rst_at) begin
        i_rst = 1'b1;
        rst_pend = 1;
      end
      if (sif.s_ready) begin
        ready_n++;
        if (ready_n == drop_at) sif.s_valid = 1'b0;
        accepted = sif.s_valid;
      end
      @(negedge clk);
    end
    timed_out = 1;
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_busy || o_done || o_tx_en) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_len = 8'd0;
    sif.s_byte = 8'h00; sif.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", all_outs(), 6'd0);
    i_rst = 1'b0;
    @(negedge clk);

    // "123456789" with the standard check value
    for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
    run_frame(9, 0, -1, 0);
    check_eq("f1_timeout", timed_out, 0);
    check_eq("f1_latency", latency, 1);
    check_eq("f1_hdr", field(0, 16), 16'hEB90);
    check_eq("f1_len", field(16, 8), 16'h0009);
    for (int i = 0; i < 9; i++) check_eq($sformatf("f1_byte%0d", i), field(24 + 8 * i, 8), 16'h0031 + 16'(i));
    check_eq("f1_crc", field(96, 16), 16'hAEE7);
    check_eq("f1_en", en_cnt, 112);
    check_eq("f1_done", done_cnt, 1);
    check_eq("f1_err", err_cnt, 0);
    check_eq("f1_gap", gap_len, 8);
    check_eq("f1_txlow", tx_bad, 0);

    // single zero byte
    payload[0] = 8'h00;
    run_frame(1, 0, -1, 0);
    check_eq("f2_en", en_cnt, 48);
    check_eq("f2_crc", field(32, 16), model_crc(1));
    check_eq("f2_done", done_cnt, 1);

    // underrun at third s_ready pulse of 5-byte frame
    for (int i = 0; i < 5; i++) payload[i] = 8'hA0 + 8'(i);
    run_frame(5, 3, -1, 0);
    check_eq("ur_en", en_cnt, 40);
    check_eq("ur_err", err_cnt, 1);
    check_eq("ur_done", done_cnt, 0);
    check_eq("ur_gap", gap_len, 8);
    check_eq("ur_txlow", tx_bad, 0);

    // reset mid-frame at bit 20
    run_frame(4, 0, 20, 0);
    check_eq("rst_outs", rst_outs, 6'd0);
    check_eq("rst_done", done_cnt, 0);
    check_eq("rst_err", err_cnt, 0);
    @(negedge clk);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) payload[i] = 8'($urandom);
    run_frame(3, 0, -1, 0);
    check_eq("post_rst_en", en_cnt, 64);
    check_eq("post_rst_crc", field(48, 16), model_crc(3));
    check_eq("post_rst_done", done_cnt, 1);

    // start during GAP ignored, then zero-length start ignored
    payload[0] = 8'h5A; payload[1] = 8'hC3;
    run_frame(2, 0, -1, 3);
    check_eq("gs_done", done_cnt, 1);
    idle_check("gs_ignored", 4);
    i_start = 1'b1; i_len = 8'd0;
    idle_check("len0_ignored", 4);

    // back-to-back: start in first IDLE cycle after GAP
    run_frame(2, 0, -1, 0);
    for (int i = 0; i < 4; i++) payload[i] = 8'h11 * 8'(i + 1);
    run_frame(4, 0, -1, 0);
    check_eq("b2b_latency", latency, 1);
    check_eq("b2b_en", en_cnt, 72);
    check_eq("b2b_crc", field(56, 16), model_crc(4));

    // maximum length
    for (int i = 0; i < 256; i++) payload[i] = 8'($urandom);
    run_frame(255, 0, -1, 0);
    check_eq("max_timeout", timed_out, 0);
    check_eq("max_en", en_cnt, 2080);
    check_eq("max_len", field(16, 8), 16'h00FF);
    check_eq("max_crc", field(2064, 16), model_crc(255));
    check_eq("max_done", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
